seq_det_sched: RTL

- Time-multiplexed controller that shares one "101" overlapping-sequence detector among NUM_CH serial bit-stream requesters.
- Round-robin arbiter grants one channel per cycle and pulls one bit from it.
- Per-channel 2-bit detector state is saved in a register file, stepped, and written back.
- Registered hit pulse tagged with the channel index goes to downstream event logic.

---
 rtl/seq_det_pkg.sv | 29 ++
 rtl/seq_det_sched_arb.sv | 35 +++
 rtl/seq_det_sched.sv | 104 ++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared "101" overlapping-sequence detector state and step functions.
// Used by seq_det_sched and the single-stream detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } det_state_t;

  // S3 means "101" was just completed; overlap restarts from S1/S2.
  function automatic det_state_t next_state(input det_state_t s, input logic b);
    det_state_t n;
    case (s)
      S0:      n = b ? S1 : S0;
      S1:      n = b ? S1 : S2;
      S2:      n = b ? S3 : S0;
      S3:      n = b ? S1 : S2;
      default: n = S0;
    endcase
    return n;
  endfunction

  function automatic logic is_hit(input det_state_t s);
    return (s == S3);
  endfunction

endpackage

// File: rtl/seq_det_sched_arb.sv
// Combinational round-robin arbiter: first requester at or above ptr,
// wrapping to 0. Produces one-hot grant, encoded index and any-grant flag.
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // Upper segment [ptr..N-1] first, then the wrapped segment [0..ptr-1].
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (W'(i) >= ptr)) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (W'(i) < ptr)) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = W'(i);
      end
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Time-multiplexed "101" detector shared by NUM_CH serial requesters.
// Optional per-channel saturating hit counters: define SEQ_DET_HITCNT_EN.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int NUM_CH = 4,
`ifdef SEQ_DET_HITCNT_EN
  parameter int CNT_W  = 8,
`endif
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_bit,
  input  logic [NUM_CH-1:0] ch_clr,
  output logic [NUM_CH-1:0] ch_ready,
  output logic              hit_valid,
  output logic [CH_W-1:0]   hit_ch,
`ifdef SEQ_DET_HITCNT_EN
  input  logic [CH_W-1:0]   rd_ch,
  output logic [CNT_W-1:0]  rd_cnt,
`endif
  output logic              busy
);

  logic [CH_W-1:0]   ptr;
  det_state_t        st [NUM_CH];
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gidx;
  logic              xfer;
  det_state_t        cur_st;
  det_state_t        nxt_st;
  logic              hit_now;
  logic              hit_vld_p1;
  logic [CH_W-1:0]   hit_ch_p1;
  logic              busy_p1;

  // Clear masks the grant so a cleared channel never steps in the same cycle.
  assign req = ch_valid & ~ch_clr & {NUM_CH{en & ~rst}};

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (xfer)
  );

  assign ch_ready = gnt;
  assign cur_st   = st[gidx];
  assign nxt_st   = next_state(cur_st, ch_bit[gidx]);
  assign hit_now  = xfer & is_hit(nxt_st);

  // Stage p1: state write-back and registered hit/busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      hit_vld_p1 <= 1'b0;
      hit_ch_p1  <= '0;
      busy_p1    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) st[i] <= S0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_clr[i]) st[i] <= S0;
      end
      if (xfer) begin
        st[gidx] <= nxt_st;
        ptr      <= (gidx == CH_W'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
      end
      hit_vld_p1 <= hit_now;
      if (hit_now) hit_ch_p1 <= gidx;
      busy_p1 <= xfer;
    end
  end

  assign hit_valid = hit_vld_p1;
  assign hit_ch    = hit_ch_p1;
  assign busy      = busy_p1;

`ifdef SEQ_DET_HITCNT_EN
  logic [CNT_W-1:0] hit_cnt [NUM_CH];
  logic [CNT_W-1:0] rd_cnt_p1;

  // Stage p1: counter update alongside hit_valid, registered readback.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_p1 <= '0;
      for (int i = 0; i < NUM_CH; i++) hit_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_clr[i]) hit_cnt[i] <= '0;
      end
      if (hit_now && (hit_cnt[gidx] != {CNT_W{1'b1}})) hit_cnt[gidx] <= hit_cnt[gidx] + 1'b1;
      rd_cnt_p1 <= (int'(rd_ch) < NUM_CH) ? hit_cnt[rd_ch] : '0;
    end
  end

  assign rd_cnt = rd_cnt_p1;
`endif

endmodule
